// File: rtl/lowfreq_counter_axil_slave_pkg.sv
// Shared constants, FSM state type and small helpers for the low-frequency counter.
package lowfreq_counter_pkg;

  // Register selector values (address bits [3:2])
  localparam logic [1:0] REG_CTRL   = 2'd0;
  localparam logic [1:0] REG_GATE   = 2'd1;
  localparam logic [1:0] REG_COUNT  = 2'd2;
  localparam logic [1:0] REG_STATUS = 2'd3;

  // CTRL bit positions
  localparam int CTRL_START  = 0;
  localparam int CTRL_CONT   = 1;
  localparam int CTRL_ABORT  = 2;
  localparam int CTRL_IRQ_EN = 3;

  // STATUS bit positions
  localparam int STAT_BUSY = 0;
  localparam int STAT_DONE = 1;
  localparam int STAT_OVF  = 2;

  localparam logic [1:0] RESP_OKAY = 2'b00;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GATE  = 2'd1,
    LATCH = 2'd2
  } lf_state_t;

  // Gate counter reload value: a programmed length of 0 behaves like 1.
  function automatic logic [31:0] gate_reload(input logic [31:0] gate_len);
    return (gate_len == 32'd0) ? 32'd0 : gate_len - 32'd1;
  endfunction

  // Byte-lane merge of write data into an existing 32-bit register.
  function automatic logic [31:0] apply_strb(input logic [31:0] old_val,
                                             input logic [31:0] new_val,
                                             input logic [3:0]  strb);
    logic [31:0] res;
    res = old_val;
    for (int b = 0; b < 4; b++) begin
      if (strb[b]) res[b*8 +: 8] = new_val[b*8 +: 8];
    end
    return res;
  endfunction

endpackage

// File: rtl/lowfreq_counter_axil_slave_if.sv
// AXI4-Lite bus bundle between the system master and the counter responder.
//
// Handshake rule on every channel: a transfer happens on the rising clock edge
// where VALID and READY are both high; VALID, once raised, holds together with
// its payload until that edge, and READY may depend combinationally on VALID.
interface lowfreq_counter_axil_slave_if #(
  parameter int ADDR_W = 4,
  parameter int DATA_W = 32
);
  logic [ADDR_W-1:0]   S_AXI_AWADDR;
  logic [2:0]          S_AXI_AWPROT;
  logic                S_AXI_AWVALID;
  logic                S_AXI_AWREADY;
  logic [DATA_W-1:0]   S_AXI_WDATA;
  logic [DATA_W/8-1:0] S_AXI_WSTRB;
  logic                S_AXI_WVALID;
  logic                S_AXI_WREADY;
  logic [1:0]          S_AXI_BRESP;
  logic                S_AXI_BVALID;
  logic                S_AXI_BREADY;
  logic [ADDR_W-1:0]   S_AXI_ARADDR;
  logic [2:0]          S_AXI_ARPROT;
  logic                S_AXI_ARVALID;
  logic                S_AXI_ARREADY;
  logic [DATA_W-1:0]   S_AXI_RDATA;
  logic [1:0]          S_AXI_RRESP;
  logic                S_AXI_RVALID;
  logic                S_AXI_RREADY;

  modport master (
    output S_AXI_AWADDR, S_AXI_AWPROT, S_AXI_AWVALID,
    input  S_AXI_AWREADY,
    output S_AXI_WDATA, S_AXI_WSTRB, S_AXI_WVALID,
    input  S_AXI_WREADY,
    input  S_AXI_BRESP, S_AXI_BVALID,
    output S_AXI_BREADY,
    output S_AXI_ARADDR, S_AXI_ARPROT, S_AXI_ARVALID,
    input  S_AXI_ARREADY,
    input  S_AXI_RDATA, S_AXI_RRESP, S_AXI_RVALID,
    output S_AXI_RREADY
  );

  modport slave (
    input  S_AXI_AWADDR, S_AXI_AWPROT, S_AXI_AWVALID,
    output S_AXI_AWREADY,
    input  S_AXI_WDATA, S_AXI_WSTRB, S_AXI_WVALID,
    output S_AXI_WREADY,
    output S_AXI_BRESP, S_AXI_BVALID,
    input  S_AXI_BREADY,
    input  S_AXI_ARADDR, S_AXI_ARPROT, S_AXI_ARVALID,
    output S_AXI_ARREADY,
    output S_AXI_RDATA, S_AXI_RRESP, S_AXI_RVALID,
    input  S_AXI_RREADY
  );
endinterface

// File: rtl/lowfreq_counter_axil_slave_edge.sv
// Synchroniser chain for the asynchronous sensor input followed by a
// registered rising-edge detector producing a one-cycle pulse.
module lf_edge_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic sig_in,
  output logic edge_pulse
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   last_q;

  // Shift sig_in through the synchroniser, then flag a low-to-high transition
  // one cycle after it leaves the last stage.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q     <= '0;
      last_q     <= 1'b0;
      edge_pulse <= 1'b0;
    end else begin
      sync_q     <= {sync_q[SYNC_STAGES-2:0], sig_in};
      last_q     <= sync_q[SYNC_STAGES-1];
      edge_pulse <= sync_q[SYNC_STAGES-1] & ~last_q;
    end
  end

endmodule

// File: rtl/lowfreq_counter_axil_slave.sv
// AXI4-Lite register block and gate-window edge counter. Only a 32-bit data
// bus is supported; SYNC_STAGES must be at least 2 and CNT_W at most 32.
module lowfreq_counter_axil_slave
  import lowfreq_counter_pkg::*;
#(
  parameter int C_S_AXI_DATA_WIDTH = 32,
  parameter int C_S_AXI_ADDR_WIDTH = 4,
  parameter int SYNC_STAGES        = 2,
  parameter int CNT_W              = 32
) (
  input  logic                          S_AXI_ACLK,
  input  logic                          S_AXI_ARESET,
  lowfreq_counter_axil_slave_if.slave   s_axi,
  input  logic                          sig_in,
  output logic                          irq,
  output lf_state_t                     dbg_state
);

  localparam logic [CNT_W-1:0] ACC_MAX = '1;

  logic clk;
  logic rst;
  assign clk = S_AXI_ACLK;
  assign rst = S_AXI_ARESET;

  // Bus views at the declared address width
  logic [C_S_AXI_ADDR_WIDTH-1:0] awaddr;
  logic [C_S_AXI_ADDR_WIDTH-1:0] araddr;
  assign awaddr = s_axi.S_AXI_AWADDR;
  assign araddr = s_axi.S_AXI_ARADDR;

  logic unused_bits;
  assign unused_bits = ^{awaddr[1:0], araddr[1:0], s_axi.S_AXI_AWPROT, s_axi.S_AXI_ARPROT};

  // Registers
  logic                          ctrl_cont_q;
  logic                          ctrl_irq_en_q;
  logic [31:0]                   gate_q;
  logic [CNT_W-1:0]              count_q;
  logic                          done_q;
  logic                          ovf_q;

  // Measurement engine
  lf_state_t                     state_q;
  lf_state_t                     state_d;
  logic [31:0]                   gate_cnt_q;
  logic [CNT_W-1:0]              acc_q;
  logic                          load_gate;
  logic                          do_latch;
  logic                          count_en;
  logic                          ovf_set;
  logic                          edge_pulse;
  logic                          busy;

  // Bus channel state
  logic                          bvalid_q;
  logic                          rvalid_q;
  logic [C_S_AXI_DATA_WIDTH-1:0] rdata_q;
  logic [C_S_AXI_DATA_WIDTH-1:0] rd_word;
  logic [31:0]                   rd_count;

  logic                          wr_en;
  logic                          rd_en;
  logic [1:0]                    wr_sel;
  logic [1:0]                    rd_sel;
  logic                          ctrl_wr;
  logic                          stat_wr;
  logic                          start_req;
  logic                          abort_req;

  // ---------------------------------------------------------------------------
  // Handshakes: ready is granted in the same cycle as valid whenever the
  // previous response has drained, so each channel has a one-cycle latency.
  // ---------------------------------------------------------------------------
  assign wr_en  = !rst && s_axi.S_AXI_AWVALID && s_axi.S_AXI_WVALID && !bvalid_q;
  assign rd_en  = !rst && s_axi.S_AXI_ARVALID && !rvalid_q;
  assign wr_sel = awaddr[3:2];
  assign rd_sel = araddr[3:2];

  assign s_axi.S_AXI_AWREADY = wr_en;
  assign s_axi.S_AXI_WREADY  = wr_en;
  assign s_axi.S_AXI_ARREADY = rd_en;
  assign s_axi.S_AXI_BVALID  = bvalid_q;
  assign s_axi.S_AXI_BRESP   = RESP_OKAY;
  assign s_axi.S_AXI_RVALID  = rvalid_q;
  assign s_axi.S_AXI_RDATA   = rdata_q;
  assign s_axi.S_AXI_RRESP   = RESP_OKAY;

  assign ctrl_wr   = wr_en && (wr_sel == REG_CTRL) && s_axi.S_AXI_WSTRB[0];
  assign stat_wr   = wr_en && (wr_sel == REG_STATUS) && s_axi.S_AXI_WSTRB[0];
  assign abort_req = ctrl_wr && s_axi.S_AXI_WDATA[CTRL_ABORT];
  // Abort takes priority over a start carried in the same write.
  assign start_req = ctrl_wr && s_axi.S_AXI_WDATA[CTRL_START] && !abort_req;

  lf_edge_sync #(.SYNC_STAGES(SYNC_STAGES)) u_edge (
    .clk        (clk),
    .rst        (rst),
    .sig_in     (sig_in),
    .edge_pulse (edge_pulse)
  );

  assign busy      = (state_q != IDLE);
  assign dbg_state = state_q;
  assign irq       = done_q & ctrl_irq_en_q;

  assign count_en = (state_q == GATE) && edge_pulse && !abort_req;
  assign ovf_set  = count_en && (acc_q == ACC_MAX);

  // FSM state register.
  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Next-state and engine strobes; abort overrides whatever else is happening.
  always_comb begin
    state_d   = state_q;
    load_gate = 1'b0;
    do_latch  = 1'b0;
    case (state_q)
      IDLE: begin
        if (start_req) begin
          state_d   = GATE;
          load_gate = 1'b1;
        end
      end
      GATE: begin
        if (gate_cnt_q == 32'd0) state_d = LATCH;
      end
      LATCH: begin
        do_latch = 1'b1;
        if (ctrl_cont_q) begin
          state_d   = GATE;
          load_gate = 1'b1;
        end else begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    if (abort_req) begin
      state_d   = IDLE;
      load_gate = 1'b0;
      do_latch  = 1'b0;
    end
  end

  // Gate down-counter and saturating edge accumulator.
  always_ff @(posedge clk) begin
    if (rst) begin
      gate_cnt_q <= '0;
      acc_q      <= '0;
    end else if (abort_req) begin
      acc_q <= '0;
    end else if (load_gate) begin
      gate_cnt_q <= gate_reload(gate_q);
      acc_q      <= '0;
    end else if (state_q == GATE) begin
      if (gate_cnt_q != 32'd0) gate_cnt_q <= gate_cnt_q - 32'd1;
      if (count_en && (acc_q != ACC_MAX)) acc_q <= acc_q + 1'b1;
    end
  end

  // Software-visible registers; hardware set of done/ovf beats a same-cycle W1C.
  always_ff @(posedge clk) begin
    if (rst) begin
      ctrl_cont_q   <= 1'b0;
      ctrl_irq_en_q <= 1'b0;
      gate_q        <= '0;
      count_q       <= '0;
      done_q        <= 1'b0;
      ovf_q         <= 1'b0;
    end else begin
      if (ctrl_wr) begin
        ctrl_cont_q   <= s_axi.S_AXI_WDATA[CTRL_CONT];
        ctrl_irq_en_q <= s_axi.S_AXI_WDATA[CTRL_IRQ_EN];
      end
      if (wr_en && (wr_sel == REG_GATE))
        gate_q <= apply_strb(gate_q, s_axi.S_AXI_WDATA, s_axi.S_AXI_WSTRB);
      if (do_latch) count_q <= acc_q;
      if (do_latch)                                        done_q <= 1'b1;
      else if (stat_wr && s_axi.S_AXI_WDATA[STAT_DONE])    done_q <= 1'b0;
      if (ovf_set)                                         ovf_q  <= 1'b1;
      else if (stat_wr && s_axi.S_AXI_WDATA[STAT_OVF])     ovf_q  <= 1'b0;
    end
  end

  // Read data selection for the addressed register.
  always_comb begin
    rd_count              = '0;
    rd_count[CNT_W-1:0]   = count_q;
    rd_word               = '0;
    case (rd_sel)
      REG_CTRL: begin
        rd_word[CTRL_CONT]   = ctrl_cont_q;
        rd_word[CTRL_IRQ_EN] = ctrl_irq_en_q;
      end
      REG_GATE:  rd_word = gate_q;
      REG_COUNT: rd_word = rd_count;
      REG_STATUS: begin
        rd_word[STAT_BUSY] = busy;
        rd_word[STAT_DONE] = done_q;
        rd_word[STAT_OVF]  = ovf_q;
      end
      default: rd_word = '0;
    endcase
  end

  // Write response: raised after an accepted write, held until BREADY.
  always_ff @(posedge clk) begin
    if (rst)                         bvalid_q <= 1'b0;
    else if (wr_en)                  bvalid_q <= 1'b1;
    else if (s_axi.S_AXI_BREADY)     bvalid_q <= 1'b0;
  end

  // Read response: data captured on the address handshake and held until RREADY.
  always_ff @(posedge clk) begin
    if (rst) begin
      rvalid_q <= 1'b0;
      rdata_q  <= '0;
    end else if (rd_en) begin
      rvalid_q <= 1'b1;
      rdata_q  <= rd_word;
    end else if (s_axi.S_AXI_RREADY) begin
      rvalid_q <= 1'b0;
    end
  end

endmodule

// File: tb/tb_lowfreq_counter_axil_slave.sv
// Directed bench for the low-frequency counter: two instances (32-bit and
// 4-bit accumulator) share one stimulus stream.
module tb_lowfreq_counter_axil_slave;
  import lowfreq_counter_pkg::*;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- bus + DUTs ----------------
  lowfreq_counter_axil_slave_if #(.ADDR_W(4), .DATA_W(32)) bus  ();
  lowfreq_counter_axil_slave_if #(.ADDR_W(4), .DATA_W(32)) bus4 ();

  logic [3:0]  awaddr = '0, araddr = '0, wstrb = '0;
  logic [31:0] wdata = '0;
  logic        awvalid = 0, wvalid = 0, bready = 0, arvalid = 0, rready = 0;

  assign bus.S_AXI_AWADDR  = awaddr;  assign bus4.S_AXI_AWADDR  = awaddr;
  assign bus.S_AXI_AWPROT  = 3'b000;  assign bus4.S_AXI_AWPROT  = 3'b000;
  assign bus.S_AXI_AWVALID = awvalid; assign bus4.S_AXI_AWVALID = awvalid;
  assign bus.S_AXI_WDATA   = wdata;   assign bus4.S_AXI_WDATA   = wdata;
  assign bus.S_AXI_WSTRB   = wstrb;   assign bus4.S_AXI_WSTRB   = wstrb;
  assign bus.S_AXI_WVALID  = wvalid;  assign bus4.S_AXI_WVALID  = wvalid;
  assign bus.S_AXI_BREADY  = bready;  assign bus4.S_AXI_BREADY  = bready;
  assign bus.S_AXI_ARADDR  = araddr;  assign bus4.S_AXI_ARADDR  = araddr;
  assign bus.S_AXI_ARPROT  = 3'b000;  assign bus4.S_AXI_ARPROT  = 3'b000;
  assign bus.S_AXI_ARVALID = arvalid; assign bus4.S_AXI_ARVALID = arvalid;
  assign bus.S_AXI_RREADY  = rready;  assign bus4.S_AXI_RREADY  = rready;

  // sensor stimulus: free-running square wave or a manual level
  int   sig_period = 10;
  int   sig_ph = 0;
  logic sig_en = 1'b0, sig_man = 1'b0, sig_gen = 1'b0;
  logic sig_in;
  always begin
    @(posedge clk); #1;
    if (sig_ph + 1 >= sig_period) sig_ph = 0; else sig_ph = sig_ph + 1;
    sig_gen = (sig_ph < sig_period / 2);
  end
  assign sig_in = sig_en ? sig_gen : sig_man;

  logic      irq, irq4;
  lf_state_t dbg_state, dbg_state4;

  lowfreq_counter_axil_slave #(.C_S_AXI_DATA_WIDTH(32), .C_S_AXI_ADDR_WIDTH(4),
                               .SYNC_STAGES(2), .CNT_W(32)) dut (
    .S_AXI_ACLK(clk), .S_AXI_ARESET(rst), .s_axi(bus.slave),
    .sig_in(sig_in), .irq(irq), .dbg_state(dbg_state));

  lowfreq_counter_axil_slave #(.C_S_AXI_DATA_WIDTH(32), .C_S_AXI_ADDR_WIDTH(4),
                               .SYNC_STAGES(2), .CNT_W(4)) dut4 (
    .S_AXI_ACLK(clk), .S_AXI_ARESET(rst), .s_axi(bus4.slave),
    .sig_in(sig_in), .irq(irq4), .dbg_state(dbg_state4));

  // ---------------- checking ----------------
  int checks = 0;
  int failures = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic axi_write(input logic [3:0] a, input logic [31:0] d,
                           input logic [3:0] s, input string tag);
    int t;
    @(posedge clk); #1;
    awaddr = a; wdata = d; wstrb = s; awvalid = 1'b1; wvalid = 1'b1;
    t = 0; @(negedge clk);
    while (bus.S_AXI_AWREADY !== 1'b1 && t < 16) begin @(negedge clk); t++; end
    check({tag, "_awready"}, 32'(bus.S_AXI_AWREADY), 32'd1);
    @(posedge clk); #1;
    awvalid = 1'b0; wvalid = 1'b0; bready = 1'b1;
    t = 0; @(negedge clk);
    while (bus.S_AXI_BVALID !== 1'b1 && t < 16) begin @(negedge clk); t++; end
    check({tag, "_bvalid"}, 32'(bus.S_AXI_BVALID), 32'd1);
    check({tag, "_bresp"}, 32'(bus.S_AXI_BRESP), 32'd0);
    @(posedge clk); #1;
    bready = 1'b0;
  endtask

  task automatic axi_read(input logic [3:0] a, output logic [31:0] d,
                          output logic [31:0] d4, input string tag);
    int t;
    @(posedge clk); #1;
    araddr = a; arvalid = 1'b1;
    t = 0; @(negedge clk);
    while (bus.S_AXI_ARREADY !== 1'b1 && t < 16) begin @(negedge clk); t++; end
    check({tag, "_arready"}, 32'(bus.S_AXI_ARREADY), 32'd1);
    @(posedge clk); #1;
    arvalid = 1'b0; rready = 1'b1;
    t = 0; @(negedge clk);
    while (bus.S_AXI_RVALID !== 1'b1 && t < 16) begin @(negedge clk); t++; end
    check({tag, "_rvalid"}, 32'(bus.S_AXI_RVALID), 32'd1);
    d  = bus.S_AXI_RDATA;
    d4 = bus4.S_AXI_RDATA;
    @(posedge clk); #1;
    rready = 1'b0;
  endtask

  task automatic rd_chk(input logic [3:0] a, input logic [31:0] exp, input string tag);
    logic [31:0] d, d4;
    axi_read(a, d, d4, tag);
    check(tag, d, exp);
  endtask

  task automatic rd_chk2(input logic [3:0] a, input logic [31:0] exp,
                         input logic [31:0] exp4, input string tag);
    logic [31:0] d, d4;
    axi_read(a, d, d4, tag);
    check(tag, d, exp);
    check({tag, "_w4"}, d4, exp4);
  endtask

  task automatic wait_state(input lf_state_t st, input int max_cyc, input string tag);
    int t;
    t = 0; @(negedge clk);
    while (dbg_state !== st && t < max_cyc) begin @(negedge clk); t++; end
    check(tag, 32'(dbg_state), 32'(st));
  endtask

  // ---------------- directed sequence ----------------
  int lat_cyc [3];

  initial begin
    // 1. reset: readies stay low even with valids presented
    awvalid = 1'b1; wvalid = 1'b1; arvalid = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_awready", 32'(bus.S_AXI_AWREADY), 32'd0);
    check("rst_arready", 32'(bus.S_AXI_ARREADY), 32'd0);
    check("rst_bvalid",  32'(bus.S_AXI_BVALID),  32'd0);
    check("rst_rvalid",  32'(bus.S_AXI_RVALID),  32'd0);
    check("rst_irq",     32'(irq),               32'd0);
    check("rst_state",   32'(dbg_state),         32'(IDLE));
    awvalid = 1'b0; wvalid = 1'b0; arvalid = 1'b0;
    @(posedge clk); #1 rst = 1'b0;
    rd_chk(4'h0, 32'h0, "rst_ctrl");
    rd_chk(4'h4, 32'h0, "rst_gate");
    rd_chk(4'h8, 32'h0, "rst_count");
    rd_chk(4'hC, 32'h0, "rst_status");

    // 2. register access
    sig_period = 10; sig_en = 1'b1;
    axi_write(4'h4, 32'h00000064, 4'hF, "wr_gate");
    rd_chk(4'h4, 32'h00000064, "rd_gate");
    axi_write(4'h4, 32'hAABBCCDD, 4'b0001, "wr_gate_b0");
    rd_chk(4'h4, 32'h000000DD, "rd_gate_b0");
    axi_write(4'h8, 32'hFFFFFFFF, 4'hF, "wr_count_ro");
    rd_chk(4'h8, 32'h0, "rd_count_ro");

    // 3. single shot: 100-cycle gate, one edge every 10 cycles
    axi_write(4'h4, 32'd100, 4'hF, "ss_gate");
    axi_write(4'h0, 32'h9, 4'hF, "ss_start");
    rd_chk(4'hC, 32'h1, "ss_busy");
    check("ss_irq_busy", 32'(irq), 32'd0);
    wait_state(IDLE, 150, "ss_idle");
    rd_chk(4'hC, 32'h2, "ss_done");
    rd_chk2(4'h8, 32'd10, 32'd10, "ss_count");
    check("ss_irq_on", 32'(irq), 32'd1);
    axi_write(4'h0, 32'h0, 4'hF, "ss_irq_dis");
    check("ss_irq_off", 32'(irq), 32'd0);
    axi_write(4'h0, 32'h8, 4'hF, "ss_irq_en");
    check("ss_irq_re", 32'(irq), 32'd1);
    rd_chk(4'h0, 32'h8, "ss_ctrl_rd");
    axi_write(4'hC, 32'h2, 4'hF, "ss_w1c");
    rd_chk(4'hC, 32'h0, "ss_done_clr");
    check("ss_irq_clr", 32'(irq), 32'd0);

    // 4a. zero gate: single gate cycle, edge pulse timed to land in it
    sig_en = 1'b0; sig_man = 1'b0;
    repeat (6) @(posedge clk);
    axi_write(4'h4, 32'd0, 4'hF, "zg_gate");
    @(posedge clk); #1 sig_man = 1'b1;
    @(posedge clk);
    axi_write(4'h0, 32'h1, 4'hF, "zg_start");
    rd_chk2(4'h8, 32'd1, 32'd1, "zg_count");
    rd_chk(4'hC, 32'h2, "zg_status");
    axi_write(4'hC, 32'h2, 4'hF, "zg_w1c");
    sig_man = 1'b0;

    // 4b. 160-cycle gate, period 8 -> 20 edges; the 4-bit copy saturates
    sig_period = 8; sig_en = 1'b1;
    repeat (20) @(posedge clk);
    axi_write(4'h4, 32'd160, 4'hF, "sat_gate");
    axi_write(4'h0, 32'h1, 4'hF, "sat_start");
    wait_state(IDLE, 250, "sat_idle");
    rd_chk2(4'h8, 32'd20, 32'd15, "sat_count");
    rd_chk2(4'hC, 32'h2, 32'h6, "sat_status");
    axi_write(4'hC, 32'h6, 4'hF, "sat_w1c");
    rd_chk2(4'hC, 32'h0, 32'h0, "sat_clr");

    // 5. continuous: 50-cycle gate, period 5 -> 10 per window, 51 cycles apart
    sig_period = 5;
    repeat (20) @(posedge clk);
    axi_write(4'h4, 32'd50, 4'hF, "ct_gate");
    axi_write(4'h0, 32'h3, 4'hF, "ct_start");
    for (int i = 0; i < 3; i++) begin
      wait_state(LATCH, 120, "ct_latch");
      lat_cyc[i] = cyc;
      rd_chk(4'h8, 32'd10, "ct_count");
    end
    check("ct_period_a", 32'(lat_cyc[1] - lat_cyc[0]), 32'd51);
    check("ct_period_b", 32'(lat_cyc[2] - lat_cyc[1]), 32'd51);
    axi_write(4'h0, 32'h4, 4'hF, "ab_abort");
    check("ab_state", 32'(dbg_state), 32'(IDLE));
    rd_chk(4'hC, 32'h2, "ab_status");
    rd_chk(4'h8, 32'd10, "ab_count");
    axi_write(4'h0, 32'h5, 4'hF, "ab_both");
    check("ab_both_state", 32'(dbg_state), 32'(IDLE));
    rd_chk(4'hC, 32'h2, "ab_both_status");

    // 6. back-pressure on B, with a second write waiting behind it
    @(posedge clk); #1;
    awaddr = 4'h4; wdata = 32'h12345678; wstrb = 4'hF; awvalid = 1'b1; wvalid = 1'b1; bready = 1'b0;
    @(negedge clk);
    check("bp_aw1_ready", 32'(bus.S_AXI_AWREADY), 32'd1);
    @(posedge clk); #1 wdata = 32'h000000AA;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      check("bp_bvalid_hold", 32'(bus.S_AXI_BVALID), 32'd1);
      check("bp_bresp_hold", 32'(bus.S_AXI_BRESP), 32'd0);
      check("bp_aw2_blocked", 32'(bus.S_AXI_AWREADY), 32'd0);
    end
    rd_chk(4'h4, 32'h12345678, "bp_first_wr");
    @(negedge clk);
    check("bp_bvalid_after_rd", 32'(bus.S_AXI_BVALID), 32'd1);
    bready = 1'b1;
    @(posedge clk); #1 bready = 1'b0;
    @(negedge clk);
    check("bp_aw2_ready", 32'(bus.S_AXI_AWREADY), 32'd1);
    @(posedge clk); #1;
    awvalid = 1'b0; wvalid = 1'b0; bready = 1'b1;
    @(negedge clk);
    check("bp_b2_valid", 32'(bus.S_AXI_BVALID), 32'd1);
    @(posedge clk); #1 bready = 1'b0;

    // back-pressure on R
    @(posedge clk); #1;
    araddr = 4'h4; arvalid = 1'b1; rready = 1'b0;
    @(negedge clk);
    check("bp_ar_ready", 32'(bus.S_AXI_ARREADY), 32'd1);
    @(posedge clk); #1 arvalid = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      check("bp_rvalid_hold", 32'(bus.S_AXI_RVALID), 32'd1);
      check("bp_rdata_hold", bus.S_AXI_RDATA, 32'h000000AA);
    end
    rready = 1'b1;
    @(posedge clk); #1 rready = 1'b0;
    @(negedge clk);
    check("bp_rvalid_drop", 32'(bus.S_AXI_RVALID), 32'd0);

    // 7. reset during a measurement with a read response in flight
    axi_write(4'h0, 32'h9, 4'hF, "mr_start");
    check("mr_busy", 32'(dbg_state), 32'(GATE));
    @(posedge clk); #1;
    araddr = 4'h8; arvalid = 1'b1; rready = 1'b0;
    @(posedge clk); #1;
    arvalid = 1'b0; rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("mr_rvalid", 32'(bus.S_AXI_RVALID), 32'd0);
    check("mr_state", 32'(dbg_state), 32'(IDLE));
    check("mr_irq", 32'(irq), 32'd0);
    @(posedge clk); #1 rst = 1'b0;
    rd_chk(4'h0, 32'h0, "mr_ctrl");
    rd_chk(4'h4, 32'h0, "mr_gate");
    rd_chk(4'h8, 32'h0, "mr_count");
    rd_chk(4'hC, 32'h0, "mr_status");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Hard stop if the sequence ever stalls.
  initial begin
    #500000;
    $display("FAIL watchdog sequence_incomplete checks=%0d", checks);
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/lowfreq_counter_axil_slave.md
Name: lowfreq_counter_axil_slave

Overview:
AXI4-Lite responder and measurement engine for the low-frequency counter IP.
- Accepts single-beat AXI4-Lite writes and reads from the system master.
- Counts rising edges of an asynchronous sensor input over a programmable gate window of ACLK cycles.
- Exposes control, gate length, result and status as four 32-bit registers at offsets 0x0–0xC.

Parameters:
- C_S_AXI_DATA_WIDTH, 32: AXI data width; only 32 is supported.
- C_S_AXI_ADDR_WIDTH, 4: AXI address width; addr[3:2] selects the register.
- SYNC_STAGES, 2: synchroniser flops on sig_in; minimum 2.
- CNT_W, 32: edge accumulator and COUNT register width; must be ≤ 32.

Ports:
- S_AXI_ACLK, in, 1: the single clock.
- S_AXI_ARESET, in, 1: synchronous, active-high reset.
- S_AXI_AWADDR, in, C_S_AXI_ADDR_WIDTH: write address.
- S_AXI_AWPROT, in, 3: ignored.
- S_AXI_AWVALID / S_AXI_AWREADY, in / out, 1: write-address handshake.
- S_AXI_WDATA, in, 32: write data.
- S_AXI_WSTRB, in, 4: byte enables.
- S_AXI_WVALID / S_AXI_WREADY, in / out, 1: write-data handshake.
- S_AXI_BRESP, out, 2: always 2'b00 (OKAY).
- S_AXI_BVALID / S_AXI_BREADY, out / in, 1: write-response handshake.
- S_AXI_ARADDR, in, C_S_AXI_ADDR_WIDTH: read address.
- S_AXI_ARPROT, in, 3: ignored.
- S_AXI_ARVALID / S_AXI_ARREADY, in / out, 1: read-address handshake.
- S_AXI_RDATA, out, 32: read data.
- S_AXI_RRESP, out, 2: always 2'b00 (OKAY).
- S_AXI_RVALID / S_AXI_RREADY, out / in, 1: read-data handshake.
- sig_in, in, 1: asynchronous sensor pulse input.
- irq, out, 1: level interrupt, equals STATUS.done AND CTRL.irq_en.

Behaviour:
- Reset values: all READY/VALID outputs 0, RDATA 0, all registers 0, FSM in IDLE, irq 0.
- Write channel:
  - AWREADY and WREADY assert together for exactly one cycle when AWVALID, WVALID and !BVALID are all true.
  - Register update happens on that cycle, byte-wise per WSTRB.
  - BVALID sets the next cycle and holds until BREADY; no new write is accepted while BVALID=1.
- Read channel:
  - ARREADY pulses for one cycle when ARVALID and !RVALID.
  - RDATA is registered and RVALID is asserted the next cycle; RDATA is stable until RREADY.
  - Latency is 1 cycle for writes and reads.
  - Read and write on the same cycle are independent.
- Register map:
  - 0x0 CTRL (RW):
    - bit0 start: self-clearing pulse, reads 0.
    - bit1 continuous.
    - bit2 abort: self-clearing, reads 0.
    - bit3 irq_en.
  - 0x4 GATE (RW): gate length in ACLK cycles; 0 is treated as 1.
  - 0x8 COUNT (RO): last completed result, zero-extended to 32 bits; writes ignored, BRESP still OKAY.
  - 0xC STATUS: bit0 busy (RO), bit1 done (W1C), bit2 ovf (W1C); other bits read 0.
- Edge path: sig_in passes through SYNC_STAGES flops, then rising-edge detect (1-cycle pulse, 1 cycle after the last sync stage).
- FSM states: IDLE, GATE, LATCH.
  - IDLE -> GATE on start: gate_cnt loaded with max(GATE,1)-1, acc cleared, busy=1.
  - GATE: acc increments on each edge pulse. acc saturates at 2^CNT_W-1; an edge arriving at saturation sets ovf.
  - GATE: gate_cnt decrements each cycle; on gate_cnt==0 go to LATCH. An edge on that final cycle is counted.
  - LATCH (1 cycle): COUNT<=acc, done<=1, then:
    - if continuous=1: back to GATE with reload, with no missed cycle beyond LATCH;
    - else: go to IDLE, busy=0.
- Start while busy: ignored.
- Abort in any state: go to IDLE next cycle, acc cleared, COUNT/done/ovf unchanged. Abort and start in the same write: abort wins.
- A GATE write during a measurement takes effect on the next reload.
- W1C of done/ovf in the same cycle hardware sets it: set wins.
- Reset mid-measurement: everything returns to reset values; an in-flight AXI response is dropped (BVALID/RVALID=0).

Decomposition:
- Package lowfreq_counter_pkg holds:
  - register offsets REG_CTRL=2'd0, REG_GATE=2'd1, REG_COUNT=2'd2, REG_STATUS=2'd3;
  - CTRL/STATUS bit-index constants;
  - the typedef enum for the FSM state (IDLE, GATE, LATCH).
- One sub-module: lf_edge_sync (SYNC_STAGES synchroniser plus rising-edge pulse).

Test Plan:
1. Reset -> BVALID=RVALID=0; reads of 0x0/0x4/0x8/0xC return 0.
2. Register access:
   - write GATE=0x64 with WSTRB=4'hF -> BRESP=0; read returns 0x00000064;
   - write 0xAABBCCDD with WSTRB=4'b0001 -> read returns 0x000000DD.
3. Single-shot measurement: GATE=100, start=1, sig_in period 10 cycles -> STATUS.busy=1 during gate, then done=1, COUNT=10, irq follows irq_en; write 0x2 to STATUS -> done=0.
4. Zero and saturating gate:
   - GATE=0, start, with one edge aligned to the single gate cycle -> COUNT=1.
   - CNT_W=4, 20 edges in the gate -> COUNT=15, ovf=1.
5. Continuous mode and abort:
   - continuous=1, GATE=50, sig_in period 5 -> COUNT=10 on every LATCH, consecutive LATCHes exactly 51 cycles apart;
   - then abort -> busy=0 next cycle, COUNT stays 10.
6. Back-pressure: hold BREADY/RREADY low 8 cycles -> BVALID/RVALID and RDATA stable throughout; a second AWVALID+WVALID is not accepted until B completes.
